// File: rtl/counter_seq_checker_if.sv
// Count stream from an up-counter to its consumer.
// The counter drives the master side and the checker listens on the slave side.
interface counter_seq_checker_if #(
    parameter int WIDTH = 8
) ();
    logic             sample_en;
    logic [WIDTH-1:0] count_in;

    modport master (output sample_en, output count_in);
    modport slave  (input  sample_en, input  count_in);
endinterface

// File: rtl/counter_seq_checker.sv
// On-chip monitor that checks a counter stream advances by exactly one per sample.
// It locks after LOCK_CNT good steps, then reports errors and wraps.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_UNSYNC  | no reference yet; the next sample becomes the reference
//   ST_ACQUIRE | counting consecutive +1 steps toward LOCK_CNT
//   ST_LOCKED  | stream trusted; a mismatch is an error, MAX->0 is a wrap
module counter_seq_checker #(
    parameter int WIDTH      = 8,
    parameter int LOCK_CNT   = 4,
    parameter int ERR_CNT_W  = 8,
    parameter int WRAP_CNT_W = 8,
    parameter int ALLOW_HOLD = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    counter_seq_checker_if.slave   cnt_if,
    input  logic                   clear,
    output logic                   locked,
    output logic                   err_pulse,
    output logic                   err_sticky,
    output logic [ERR_CNT_W-1:0]   err_count,
    output logic                   wrap_pulse,
    output logic [WRAP_CNT_W-1:0]  wrap_count
);

    localparam int GOOD_W = 8;

    typedef enum logic [1:0] {
        ST_UNSYNC  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t                state_q,      state_d;
    logic [WIDTH-1:0]      ref_val_q,    ref_val_d;
    logic [GOOD_W-1:0]     good_q,       good_d;
    logic                  locked_q,     locked_d;
    logic                  err_pulse_q,  err_pulse_d;
    logic                  err_sticky_q, err_sticky_d;
    logic [ERR_CNT_W-1:0]  err_count_q,  err_count_d;
    logic                  wrap_pulse_q, wrap_pulse_d;
    logic [WRAP_CNT_W-1:0] wrap_count_q, wrap_count_d;

    logic                  sample_en;
    logic [WIDTH-1:0]      count_in;
    logic [WIDTH-1:0]      ref_plus_one;
    logic                  is_match;
    logic                  is_hold;
    logic                  err_ev;
    logic                  wrap_ev;

    assign sample_en    = cnt_if.sample_en;
    assign count_in     = cnt_if.count_in;
    assign ref_plus_one = ref_val_q + WIDTH'(1);
    assign is_match     = (count_in == ref_plus_one);
    assign is_hold      = (ALLOW_HOLD != 0) && (count_in == ref_val_q);

    always_comb begin
        state_d   = state_q;
        ref_val_d = ref_val_q;
        good_d    = good_q;
        err_ev    = 1'b0;
        wrap_ev   = 1'b0;

        if (sample_en) begin
            unique case (state_q)
                ST_UNSYNC: begin
                    ref_val_d = count_in;
                    good_d    = '0;
                    state_d   = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (is_match) begin
                        ref_val_d = count_in;
                        good_d    = good_q + GOOD_W'(1);
                        if (good_q + GOOD_W'(1) == GOOD_W'(LOCK_CNT)) begin
                            state_d = ST_LOCKED;
                        end
                    end else if (!is_hold) begin
                        ref_val_d = count_in;
                        good_d    = '0;
                    end
                end
                ST_LOCKED: begin
                    if (is_match) begin
                        ref_val_d = count_in;
                        wrap_ev   = (ref_val_q == '1);
                    end else if (!is_hold) begin
                        err_ev    = 1'b1;
                        ref_val_d = count_in;
                        good_d    = '0;
                        state_d   = ST_ACQUIRE;
                    end
                end
                default: state_d = ST_UNSYNC;
            endcase
        end
    end

    // A clear coinciding with an event keeps that event as the first new count.
    always_comb begin
        locked_d     = (state_d == ST_LOCKED);
        err_pulse_d  = err_ev;
        wrap_pulse_d = wrap_ev;
        err_sticky_d = err_sticky_q | err_ev;
        err_count_d  = err_count_q;
        wrap_count_d = wrap_count_q;

        if (clear) begin
            err_sticky_d = err_ev;
            err_count_d  = err_ev  ? ERR_CNT_W'(1)  : '0;
            wrap_count_d = wrap_ev ? WRAP_CNT_W'(1) : '0;
        end else begin
            if (err_ev && (err_count_q != '1)) begin
                err_count_d = err_count_q + ERR_CNT_W'(1);
            end
            if (wrap_ev && (wrap_count_q != '1)) begin
                wrap_count_d = wrap_count_q + WRAP_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_UNSYNC;
            ref_val_q    <= '0;
            good_q       <= '0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
            wrap_pulse_q <= 1'b0;
            wrap_count_q <= '0;
        end else begin
            state_q      <= state_d;
            ref_val_q    <= ref_val_d;
            good_q       <= good_d;
            locked_q     <= locked_d;
            err_pulse_q  <= err_pulse_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
            wrap_pulse_q <= wrap_pulse_d;
            wrap_count_q <= wrap_count_d;
        end
    end

    assign locked     = locked_q;
    assign err_pulse  = err_pulse_q;
    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;
    assign wrap_pulse = wrap_pulse_q;
    assign wrap_count = wrap_count_q;

endmodule

// File: tb/tb_counter_seq_checker.sv
// Bench for counter_seq_checker: two instances (hold rejected / hold accepted)
// share one stimulus stream and are compared every cycle against a reference model.
module tb_counter_seq_checker;

    localparam int S_UNSYNC  = 0;
    localparam int S_ACQUIRE = 1;
    localparam int S_LOCKED  = 2;
    localparam int LOCK_N    = 4;

    logic clk = 1'b0;
    logic rst;
    logic clear;

    logic [1:0] locked_o;
    logic [1:0] err_pulse_o;
    logic [1:0] err_sticky_o;
    logic [7:0] err_count_o  [2];
    logic [1:0] wrap_pulse_o;
    logic [7:0] wrap_count_o [2];

    int n_tests = 0;
    int n_fail  = 0;

    int m_state [2];
    int m_ref   [2];
    int m_good  [2];
    int e_locked[2];
    int e_errp  [2];
    int e_errs  [2];
    int e_errc  [2];
    int e_wrapp [2];
    int e_wrapc [2];

    int last_cin;

    always #5 clk = ~clk;

    counter_seq_checker_if #(.WIDTH(8)) cnt_if ();

    counter_seq_checker #(.WIDTH(8), .LOCK_CNT(LOCK_N), .ERR_CNT_W(8), .WRAP_CNT_W(8), .ALLOW_HOLD(0)) u_dut_nohold (
        .clk        (clk),
        .rst        (rst),
        .cnt_if     (cnt_if),
        .clear      (clear),
        .locked     (locked_o[0]),
        .err_pulse  (err_pulse_o[0]),
        .err_sticky (err_sticky_o[0]),
        .err_count  (err_count_o[0]),
        .wrap_pulse (wrap_pulse_o[0]),
        .wrap_count (wrap_count_o[0])
    );

    counter_seq_checker #(.WIDTH(8), .LOCK_CNT(LOCK_N), .ERR_CNT_W(8), .WRAP_CNT_W(8), .ALLOW_HOLD(1)) u_dut_hold (
        .clk        (clk),
        .rst        (rst),
        .cnt_if     (cnt_if),
        .clear      (clear),
        .locked     (locked_o[1]),
        .err_pulse  (err_pulse_o[1]),
        .err_sticky (err_sticky_o[1]),
        .err_count  (err_count_o[1]),
        .wrap_pulse (wrap_pulse_o[1]),
        .wrap_count (wrap_count_o[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: spec rules applied to one sample, h=1 accepts holds.
    task automatic model_update(input int h, input bit r, input bit se, input int cin, input bit clr);
        bit err;
        bit wrap;
        bit match;
        bit hold;
        err  = 0;
        wrap = 0;
        if (r) begin
            m_state[h] = S_UNSYNC;
            m_ref[h]   = 0;
            m_good[h]  = 0;
            e_errs[h]  = 0;
            e_errc[h]  = 0;
            e_wrapc[h] = 0;
        end else begin
            if (se) begin
                match = (cin == ((m_ref[h] + 1) % 256));
                hold  = (h == 1) && (cin == m_ref[h]);
                if (m_state[h] == S_UNSYNC) begin
                    m_ref[h]   = cin;
                    m_good[h]  = 0;
                    m_state[h] = S_ACQUIRE;
                end else if (m_state[h] == S_ACQUIRE) begin
                    if (match) begin
                        m_ref[h]  = cin;
                        m_good[h] = m_good[h] + 1;
                        if (m_good[h] == LOCK_N) m_state[h] = S_LOCKED;
                    end else if (!hold) begin
                        m_ref[h]  = cin;
                        m_good[h] = 0;
                    end
                end else begin
                    if (match) begin
                        wrap     = (m_ref[h] == 255) && (cin == 0);
                        m_ref[h] = cin;
                    end else if (!hold) begin
                        err        = 1;
                        m_ref[h]   = cin;
                        m_good[h]  = 0;
                        m_state[h] = S_ACQUIRE;
                    end
                end
            end
            if (clr) begin
                e_errc[h]  = err;
                e_errs[h]  = err;
                e_wrapc[h] = wrap;
            end else begin
                if (err)  e_errc[h]  = (e_errc[h]  >= 255) ? 255 : e_errc[h]  + 1;
                if (wrap) e_wrapc[h] = (e_wrapc[h] >= 255) ? 255 : e_wrapc[h] + 1;
                if (err)  e_errs[h]  = 1;
            end
        end
        e_errp[h]   = err;
        e_wrapp[h]  = wrap;
        e_locked[h] = (m_state[h] == S_LOCKED);
    endtask

    task automatic compare_all();
        for (int h = 0; h < 2; h++) begin
            check($sformatf("locked[%0d]", h),     32'(locked_o[h]),     32'(e_locked[h]));
            check($sformatf("err_pulse[%0d]", h),  32'(err_pulse_o[h]),  32'(e_errp[h]));
            check($sformatf("err_sticky[%0d]", h), 32'(err_sticky_o[h]), 32'(e_errs[h]));
            check($sformatf("err_count[%0d]", h),  32'(err_count_o[h]),  32'(e_errc[h]));
            check($sformatf("wrap_pulse[%0d]", h), 32'(wrap_pulse_o[h]), 32'(e_wrapp[h]));
            check($sformatf("wrap_count[%0d]", h), 32'(wrap_count_o[h]), 32'(e_wrapc[h]));
        end
    endtask

    task automatic step(input bit se, input int cin, input bit clr, input bit r);
        cnt_if.sample_en = se;
        cnt_if.count_in  = 8'(cin);
        clear            = clr;
        rst              = r;
        @(posedge clk);
        for (int h = 0; h < 2; h++) model_update(h, r, se, cin % 256, clr);
        if (se) last_cin = cin % 256;
        #1;
        compare_all();
    endtask

    task automatic feed(input int v);
        step(1'b1, v, 1'b0, 1'b0);
    endtask

    initial begin
        int v;
        int p;
        bit se_r;
        bit clr_r;
        bit rst_r;

        cnt_if.sample_en = 1'b0;
        cnt_if.count_in  = 8'd0;
        clear            = 1'b0;
        rst              = 1'b1;
        last_cin         = 0;
        for (int h = 0; h < 2; h++) model_update(h, 1'b1, 1'b0, 0, 1'b0);

        // Reset with random inputs
        for (int i = 0; i < 2; i++) step(1'($urandom), int'($urandom_range(0, 255)), 1'b0, 1'b1);
        check("rst_locked", 32'(locked_o), 32'd0);
        check("rst_errc",   32'(err_count_o[0]), 32'd0);

        // Lock on 0..4
        for (int i = 0; i <= 3; i++) feed(i);
        check("lock_pre", 32'(locked_o), 32'd0);
        feed(4);
        check("lock_at4", 32'(locked_o), 32'd3);

        // Run through a wrap
        for (int i = 5; i <= 255; i++) feed(i);
        feed(0);
        check("wrap_pulse_dir", 32'(wrap_pulse_o), 32'd3);
        check("wrap_count_dir", 32'(wrap_count_o[0]), 32'd1);
        check("wrap_errc_dir",  32'(err_count_o[1]), 32'd0);

        // Error while locked, then re-lock
        for (int i = 1; i <= 'h20; i++) feed(i);
        feed('h37);
        check("err_pulse_dir", 32'(err_pulse_o), 32'd3);
        check("err_count_dir", 32'(err_count_o[0]), 32'd1);
        check("err_locked_dir", 32'(locked_o), 32'd0);
        feed('h38);
        check("err_pulse_off", 32'(err_pulse_o), 32'd0);
        feed('h39);
        feed('h3A);
        check("relock_pre", 32'(locked_o), 32'd0);
        feed('h3B);
        check("relock_dir", 32'(locked_o), 32'd3);

        // Gaps: count advances only on enabled cycles
        v = 'h3C;
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) begin
                step(1'b1, v, 1'b0, 1'b0);
                v++;
            end else begin
                step(1'b0, int'($urandom_range(0, 255)), 1'b0, 1'b0);
            end
        end
        check("gap_locked", 32'(locked_o), 32'd3);
        check("gap_errc",   32'(err_count_o[0]), 32'd1);

        // Hold: repeat 0x10
        while (v != 'h111) begin
            feed(v % 256);
            v++;
        end
        feed('h10);
        check("hold_errc_nohold", 32'(err_count_o[0]), 32'd2);
        check("hold_errc_hold",   32'(err_count_o[1]), 32'd1);
        for (int i = 'h11; i <= 'h14; i++) feed(i);

        // clear alone, then clear with an error
        step(1'b0, 0, 1'b1, 1'b0);
        check("clr_errc",   32'(err_count_o[0]), 32'd0);
        check("clr_locked", 32'(locked_o), 32'd3);
        step(1'b1, 'h50, 1'b1, 1'b0);
        check("clr_err_errc", 32'(err_count_o[0]), 32'd1);

        // Saturation: 300 errors with re-lock between them
        for (int k = 0; k < 300; k++) begin
            for (int i = 1; i <= LOCK_N; i++) feed((last_cin + 1) % 256);
            feed((last_cin + 2 + int'($urandom_range(0, 200))) % 256);
        end
        check("sat_errc", 32'(err_count_o[1]), 32'd255);

        // Reset mid-lock
        for (int i = 1; i <= LOCK_N; i++) feed((last_cin + 1) % 256);
        check("prerst_locked", 32'(locked_o), 32'd3);
        step(1'b1, (last_cin + 1) % 256, 1'b0, 1'b1);
        check("midrst_errc", 32'(err_count_o[0]), 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst_r = ($urandom_range(0, 199) == 0);
            se_r  = ($urandom_range(0, 3) != 0);
            clr_r = ($urandom_range(0, 59) == 0);
            p     = int'($urandom_range(0, 99));
            if (!se_r)       v = int'($urandom_range(0, 255));
            else if (p < 82) v = (last_cin + 1) % 256;
            else if (p < 90) v = last_cin;
            else             v = int'($urandom_range(0, 255));
            step(se_r, v, clr_r, rst_r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_seq_checker.md
Name: counter_seq_checker

Overview:
- Consumes the count stream from an up-counter (e.g. counter_8_bit) and checks that successive sampled values increment by exactly one modulo 2^WIDTH.
- Acquires lock after a run of good increments, then reports sequence errors and wrap-arounds through pulses and saturating counters.
- Sits beside the counter as an on-chip monitor. It is the consuming end of the counter's output interface.

Parameters:
- WIDTH, 8, width of the checked count value.
- LOCK_CNT, 4, consecutive correct increments needed to enter LOCKED (legal range 1..255).
- ERR_CNT_W, 8, width of err_count.
- WRAP_CNT_W, 8, width of wrap_count.
- ALLOW_HOLD, 0, if 1 a sample equal to the previous sample is accepted (no advance, no error); if 0 it is a mismatch.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- sample_en  in  1  count_in is valid this cycle.
- count_in  in  WIDTH  counter value under check.
- clear  in  1  synchronous clear of err_count, err_sticky and wrap_count.
- locked  out  1  high while FSM is in LOCKED.
- err_pulse  out  1  one-cycle pulse per sequence error.
- err_sticky  out  1  set on any error, held until clear or rst.
- err_count  out  ERR_CNT_W  saturating error count.
- wrap_pulse  out  1  one-cycle pulse on an accepted MAX->0 transition while LOCKED.
- wrap_count  out  WRAP_CNT_W  saturating wrap count.

Behaviour:
- Reset and registers:
  - All outputs are registered.
  - rst has priority over every other input.
  - On rst: state=UNSYNC; ref=0; good=0; all outputs 0.
- Sampling and latency:
  - A sample is taken only when sample_en=1. Cycles with sample_en=0 change no state and hold the pulses low.
  - Responses appear on the cycle after the sampled edge, i.e. 1-cycle latency.
- Definitions:
  - match: count_in == ref+1 mod 2^WIDTH.
  - hold: count_in == ref with ALLOW_HOLD=1. A hold changes nothing except that ref keeps its value.
- FSM states: UNSYNC, ACQUIRE, LOCKED.
- UNSYNC:
  - On a sample: ref<=count_in, good<=0, go to ACQUIRE.
- ACQUIRE:
  - On a match: ref<=count_in, good<=good+1. If good+1==LOCK_CNT, go to LOCKED.
  - On a mismatch: ref<=count_in, good<=0, stay in ACQUIRE. No error is reported; errors count only in LOCKED.
- LOCKED:
  - On a match: ref<=count_in. If ref==2^WIDTH-1 and count_in==0, pulse wrap_pulse and increment wrap_count.
  - On a mismatch:
    - Pulse err_pulse, set err_sticky, increment err_count.
    - ref<=count_in, good<=0, go to ACQUIRE. locked falls on the same edge that raises err_pulse.
- Wraps during ACQUIRE are not counted.
- Saturation: err_count and wrap_count stop at all-ones and do not wrap.
- clear:
  - Zeroes err_count, err_sticky and wrap_count. Does not affect state, ref, good or locked.
  - clear together with an error in the same cycle: err_count<=1, err_sticky<=1.
  - clear together with a wrap in the same cycle: wrap_count<=1.
- rst during LOCKED or ACQUIRE: return to UNSYNC next cycle. Re-lock needs 1+LOCK_CNT fresh samples.
- No X propagation: count_in is ignored when sample_en=0.

Test Plan:
- Reset: rst=1 for 2 cycles with random count_in and sample_en -> all outputs 0, locked=0.
- Lock and wrap: WIDTH=8, LOCK_CNT=4, sample_en=1 every cycle, count_in 0,1,2,…
  - locked rises 1 cycle after the sample of value 4.
  - Feeding 0..255,0 gives wrap_pulse one cycle after the 0 sample, wrap_count=1, err_count=0.
- Error and re-lock: while locked, feed 0x20 then 0x37.
  - err_pulse for exactly 1 cycle, err_count=1, err_sticky=1, locked=0.
  - Continue 0x38..0x3B -> locked returns after the 0x3B sample.
- Gaps and hold:
  - Toggle sample_en with count_in stepping only on enabled cycles -> no error, lock is kept.
  - ALLOW_HOLD=1, repeat 0x10 twice -> no error.
  - ALLOW_HOLD=0, repeat 0x10 twice -> err_count+1.
- clear interactions:
  - clear alone -> counters and sticky go to 0, locked is unchanged.
  - clear in the same cycle as an error -> err_count=1, err_sticky=1.
- Saturation and reset mid-lock:
  - Force 300 errors, re-locking between them -> err_count holds at 255.
  - Then rst while locked -> UNSYNC, all outputs 0 next cycle.
